// File: rtl/ct_ebiu_lpc_ctrl_if.sv
// Low-power handshake and EBIU traffic status bundle for ct_ebiu_lpc_ctrl.
// slave: the controller side. master: the clock controller / EBIU environment side.
interface ct_ebiu_lpc_ctrl_if;
  logic       pad_ebiu_csysreq;
  logic       ebiu_read_channel_no_op;
  logic       ebiu_write_channel_no_op;
  logic       ebiu_snoop_channel_no_op;
  logic       ebiu_xx_req_pending;
  logic       ebiu_pad_csysack;
  logic       ebiu_pad_cactive;
  logic       ebiu_xx_req_block;
  logic       ebiu_xx_no_op;
  logic [2:0] ebiu_lp_state;

  modport slave (
    input  pad_ebiu_csysreq,
    input  ebiu_read_channel_no_op,
    input  ebiu_write_channel_no_op,
    input  ebiu_snoop_channel_no_op,
    input  ebiu_xx_req_pending,
    output ebiu_pad_csysack,
    output ebiu_pad_cactive,
    output ebiu_xx_req_block,
    output ebiu_xx_no_op,
    output ebiu_lp_state
  );

  modport master (
    output pad_ebiu_csysreq,
    output ebiu_read_channel_no_op,
    output ebiu_write_channel_no_op,
    output ebiu_snoop_channel_no_op,
    output ebiu_xx_req_pending,
    input  ebiu_pad_csysack,
    input  ebiu_pad_cactive,
    input  ebiu_xx_req_block,
    input  ebiu_xx_no_op,
    input  ebiu_lp_state
  );
endinterface

// File: rtl/ct_ebiu_lpc_ctrl.sv
// EBIU AXI master low-power interface controller: csysreq/csysack/cactive
// sequencing with channel drain, stop accept/deny and an idle detector.
module ct_ebiu_lpc_ctrl #(
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned IDLE_THRESH   = 16,
  parameter int unsigned DRAIN_TIMEOUT = 64
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  input  logic              clk_en,
  ct_ebiu_lpc_ctrl_if.slave lpc
);

  typedef enum logic [2:0] {
    StRun   = 3'b000,
    StDrain = 3'b001,
    StStop  = 3'b010,
    StDeny  = 3'b011,
    StWake  = 3'b100
  } lp_state_e;

  localparam logic [CNT_W-1:0] IdleThresh = CNT_W'(IDLE_THRESH);
  localparam logic [CNT_W-1:0] DrainLast  = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  lp_state_e        state_q;
  logic [CNT_W-1:0] idle_cnt_q;
  logic [CNT_W-1:0] idle_cnt_d;
  logic [CNT_W-1:0] drain_cnt_q;
  logic             csysack_q;
  logic             cactive_q;
  logic             req_block_q;
  logic             no_op;
  logic             idle;

  // Channel idle detection and the saturating next idle count used in RUN.
  always_comb begin
    no_op = lpc.ebiu_read_channel_no_op & lpc.ebiu_write_channel_no_op &
            lpc.ebiu_snoop_channel_no_op;
    idle  = no_op & ~lpc.ebiu_xx_req_pending;
    if (!idle) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q == IdleThresh) begin
      idle_cnt_d = IdleThresh;
    end else begin
      idle_cnt_d = idle_cnt_q + CntOne;
    end
  end

  // Low-power FSM with registered handshake outputs; reset beats clk_en.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q     <= StRun;
      idle_cnt_q  <= '0;
      drain_cnt_q <= '0;
      csysack_q   <= 1'b1;
      cactive_q   <= 1'b1;
      req_block_q <= 1'b0;
    end else if (clk_en) begin
      case (state_q)
        StRun: begin
          csysack_q   <= 1'b1;
          req_block_q <= 1'b0;
          idle_cnt_q  <= idle_cnt_d;
          cactive_q   <= (idle_cnt_d != IdleThresh);
          if (!lpc.pad_ebiu_csysreq) begin
            state_q     <= StDrain;
            req_block_q <= 1'b1;
            drain_cnt_q <= '0;
          end
        end
        StDrain: begin
          idle_cnt_q <= '0;
          // A withdrawn request must win: acking now would break csysack tracking csysreq.
          if (lpc.pad_ebiu_csysreq) begin
            state_q     <= StRun;
            req_block_q <= 1'b0;
          end else if (no_op) begin
            state_q   <= StStop;
            csysack_q <= 1'b0;
            cactive_q <= 1'b0;
          end else if (drain_cnt_q == DrainLast) begin
            state_q     <= StDeny;
            csysack_q   <= 1'b0;
            cactive_q   <= 1'b1;
            req_block_q <= 1'b0;
          end else begin
            drain_cnt_q <= drain_cnt_q + CntOne;
          end
        end
        StStop: begin
          if (lpc.pad_ebiu_csysreq) begin
            state_q   <= StWake;
            csysack_q <= 1'b1;
            cactive_q <= 1'b1;
          end else if (lpc.ebiu_xx_req_pending) begin
            // Wakeup request towards the clock controller; held until exit.
            cactive_q <= 1'b1;
          end
        end
        StWake: begin
          state_q     <= StRun;
          req_block_q <= 1'b0;
          idle_cnt_q  <= '0;
        end
        StDeny: begin
          if (lpc.pad_ebiu_csysreq) begin
            state_q    <= StRun;
            csysack_q  <= 1'b1;
            idle_cnt_q <= '0;
          end
        end
        default: begin
          state_q     <= StRun;
          idle_cnt_q  <= '0;
          drain_cnt_q <= '0;
          csysack_q   <= 1'b1;
          cactive_q   <= 1'b1;
          req_block_q <= 1'b0;
        end
      endcase
    end
  end

  assign lpc.ebiu_pad_csysack  = csysack_q;
  assign lpc.ebiu_pad_cactive  = cactive_q;
  assign lpc.ebiu_xx_req_block = req_block_q;
  assign lpc.ebiu_xx_no_op     = no_op;
  assign lpc.ebiu_lp_state     = state_q;

endmodule

// File: doc/ct_ebiu_lpc_ctrl.md
Name: ct_ebiu_lpc_ctrl

Overview:
Low-power interface controller for the EBIU AXI master port. It sequences the csysreq/csysack/cactive handshake with the interconnect clock controller. It drains outstanding read, write and snoop channel traffic before accepting a stop request, and it blocks new EBIU transactions while the port is stopping or stopped. It replaces the fixed cactive=1 and mirror-csysack behaviour with a real accept/deny state machine plus an idle detector.

Parameters:
CNT_W, 8, width of the idle and drain counters.
IDLE_THRESH, 16, number of consecutive idle enabled cycles before cactive is dropped in RUN. Range 1..2^CNT_W-1.
DRAIN_TIMEOUT, 64, enabled cycles allowed in DRAIN before a stop request is denied. Range 1..2^CNT_W-1.

Ports:
forever_cpuclk  in  1  free-running CPU clock.
cpurst  in  1  synchronous active-high reset.
clk_en  in  1  clock-ratio enable; all state, counter and output registers update only when clk_en=1.
pad_ebiu_csysreq  in  1  stop request from the clock controller, active-low (0 = request stop).
ebiu_read_channel_no_op  in  1  read channel idle.
ebiu_write_channel_no_op  in  1  write channel idle.
ebiu_snoop_channel_no_op  in  1  snoop channel idle.
ebiu_xx_req_pending  in  1  an upstream requester has a transaction waiting for EBIU.
ebiu_pad_csysack  out  1  stop acknowledge, registered.
ebiu_pad_cactive  out  1  port-active indication, registered.
ebiu_xx_req_block  out  1  registered; 1 = upstream must not issue new transactions.
ebiu_xx_no_op  out  1  AND of the three channel no_op inputs, combinational.
ebiu_lp_state  out  3  current state encoding, for debug and PMU.

Behaviour:
- Define idle = ebiu_xx_no_op & ~ebiu_xx_req_pending.
- Reset (cpurst=1 at a clock edge):
  - state=RUN, idle_cnt=0, drain_cnt=0.
  - csysack=1, cactive=1, req_block=0.
  - Reset has priority over clk_en and over any state.
- States and encoding: RUN=000, DRAIN=001, STOP=010, DENY=011, WAKE=100. Other codes are illegal and go to RUN on the next enabled cycle.
- RUN:
  - csysack=1, req_block=0.
  - idle_cnt increments when idle and saturates at IDLE_THRESH. It clears to 0 when not idle.
  - cactive=0 when the next idle_cnt value equals IDLE_THRESH, otherwise 1. Any non-idle cycle raises cactive on the next enabled edge.
  - csysreq=0 -> DRAIN, req_block<=1, drain_cnt<=0.
- DRAIN:
  - req_block=1, csysack=1.
  - drain_cnt increments each enabled cycle.
  - If no_op=1 -> STOP, csysack<=0, cactive<=0. Accept takes priority over timeout in the same cycle.
  - Else if drain_cnt==DRAIN_TIMEOUT-1 -> DENY, csysack<=0, cactive<=1, req_block<=0.
  - If csysreq returns to 1 before acceptance -> RUN, req_block<=0.
- STOP:
  - csysack=0, req_block=1.
  - cactive stays 0 unless req_pending=1, which sets cactive<=1 as a wakeup request. cactive stays 1 until exit.
  - csysreq=1 -> WAKE, csysack<=1, cactive<=1.
- WAKE:
  - One enabled cycle long, then RUN.
  - req_block<=0 on the transition to RUN, so the first new transaction can issue 2 enabled cycles after csysreq rises.
  - idle_cnt<=0.
- DENY:
  - csysack=0, cactive=1, req_block=0.
  - Wait for csysreq=1 -> RUN, csysack<=1, idle_cnt<=0.
- Handshake invariant: csysack only changes when it differs from csysreq, i.e. it tracks csysreq per the AXI LPI rules.
- State is unchanged while clk_en=0.
- Counters are CNT_W bits wide and never wrap: idle_cnt saturates at IDLE_THRESH, and drain_cnt stops when DENY is entered.
- ebiu_lp_state reflects the registered state.

Test Plan:
1. Reset with all no_op=1 and req_pending=0 for 20 enabled cycles -> cactive falls on enabled cycle 16 (IDLE_THRESH=16); csysack=1, block=0, state=000.
2. Idle port, drop csysreq -> DRAIN (001) for 1 cycle, then STOP (010) with csysack=0, cactive=0, block=1. Raise csysreq -> WAKE (100), csysack=1, then RUN with block=0 one cycle later.
3. Drop csysreq while write_no_op=0 for the whole window -> after 64 enabled DRAIN cycles state=DENY (011), csysack=0, cactive=1, block=0. Raise csysreq -> RUN, csysack=1.
4. In STOP, pulse req_pending for 1 cycle -> cactive rises next enabled edge and stays 1; state stays STOP until csysreq=1.
5. Toggle clk_en 1-of-2 during scenario 2 -> state and outputs change only on clk_en=1 edges; no change when clk_en=0.
6. Assert cpurst in STOP and in DRAIN -> next edge gives state=RUN, csysack=1, cactive=1, block=0, counters 0.
